cell_window_sequencer: RTL and testbench

- Raster-scan controller that feeds the cell processor from a streamed image.
- Accepts one pixel per cycle. Keeps the last CELL_N-1 image rows in line buffers.
- Assembles each CELL_N x CELL_N window (cell_t layout) and issues it to the cell processor with the frame's opcode and user input, under a valid/ready handshake.
- Sits between the image input buffer and the cell processor datapath. Sequences one frame per start command.

---
 rtl/cell_window_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_cell_window_sequencer.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cell_window_sequencer
// Description : Raster-scan window sequencer. Streams one pixel per cycle,
//               keeps the last CELL_N-1 rows in line buffers and issues every
//               full CELL_N x CELL_N window to the cell processor together
//               with the frame's latched opcode and user operand.
//               Optional macro CELL_STALL_CNT_EN adds a saturating count of
//               cycles in which a cell waits on the processor.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_window_sequencer #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int CELL_N       = 3,
  parameter int PIXEL_DEPTH  = 24,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [OPCODE_WIDTH-1:0]               opcode_in,
  input  logic [PIXEL_DEPTH-1:0]                user_in,
  input  logic [PIXEL_DEPTH-1:0]                pix_in,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  output logic [PIXEL_DEPTH*CELL_N*CELL_N-1:0]  cell_out,
  output logic                                  cell_valid,
  input  logic                                  cell_ready,
  output logic [OPCODE_WIDTH-1:0]               opcode_out,
  output logic [PIXEL_DEPTH-1:0]                user_out,
  output logic [$clog2(IMAGE_WIDTH)-1:0]        cell_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]       cell_y,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic [31:0]                           stall_cycles
);

  localparam int COL_W   = $clog2(IMAGE_WIDTH);
  localparam int ROW_W   = $clog2(IMAGE_HEIGHT);
  localparam int HALF    = (CELL_N - 1) / 2;
  localparam int LB_ROWS = CELL_N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   run_ready;
  logic                   accept;
  logic                   handoff;
  logic                   start_acc;
  logic                   last_pix;
  logic                   emit;

  // line_buf[0] is the oldest buffered row, line_buf[LB_ROWS-1] the newest.
  logic [PIXEL_DEPTH-1:0] line_buf [LB_ROWS][IMAGE_WIDTH];
  // Vertical slice of the image at the current column, top row first.
  logic [PIXEL_DEPTH-1:0] col_vec  [CELL_N];
  // win[r][c]: row r (top = 0), column c (left = 0) of the current window.
  logic [PIXEL_DEPTH-1:0] win      [CELL_N][CELL_N];

  // The output window register only advances when it is empty or being
  // handed off, so backpressure passes straight through to pix_ready.
  assign run_ready = (state == RUN) && (!cell_valid || cell_ready);
  assign pix_ready = run_ready;
  assign accept    = pix_valid && run_ready;
  assign handoff   = cell_valid && cell_ready;
  assign start_acc = (state == IDLE) && start;
  assign last_pix  = (col == COL_W'(IMAGE_WIDTH - 1)) &&
                     (row == ROW_W'(IMAGE_HEIGHT - 1));
  assign emit      = (col >= COL_W'(CELL_N - 1)) && (row >= ROW_W'(CELL_N - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status decode
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (accept && last_pix) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (!cell_valid || cell_ready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Column slice feeding the window: buffered rows above, live pixel below
  for (genvar k = 0; k < LB_ROWS; k++) begin : g_col_vec
    assign col_vec[k] = line_buf[k][col];
  end
  assign col_vec[CELL_N-1] = pix_in;

  // Line buffers: each column shifts up one row when its pixel arrives
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < LB_ROWS - 1; k++) begin
        line_buf[k][col] <= line_buf[k+1][col];
      end
      line_buf[LB_ROWS-1][col] <= pix_in;
    end
  end

  // Raster counters and per-frame opcode/operand latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      opcode_out <= '0;
      user_out   <= '0;
    end else if (start_acc) begin
      col        <= '0;
      row        <= '0;
      opcode_out <= opcode_in;
      user_out   <= user_in;
    end else if (accept) begin
      if (col == COL_W'(IMAGE_WIDTH - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMAGE_HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window shift registers double as the cell output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_valid <= 1'b0;
      cell_x     <= '0;
      cell_y     <= '0;
      for (int r = 0; r < CELL_N; r++) begin
        for (int c = 0; c < CELL_N; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < CELL_N; r++) begin
        for (int c = 0; c < CELL_N - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][CELL_N-1] <= col_vec[r];
      end
      cell_valid <= emit;
      if (emit) begin
        cell_x <= col - COL_W'(HALF);
        cell_y <= row - ROW_W'(HALF);
      end
    end else if (handoff) begin
      cell_valid <= 1'b0;
    end
  end

  // Flatten the window into pixelMatrix[r*CELL_N+c]
  for (genvar r = 0; r < CELL_N; r++) begin : g_pack_row
    for (genvar c = 0; c < CELL_N; c++) begin : g_pack_col
      assign cell_out[(r*CELL_N+c)*PIXEL_DEPTH +: PIXEL_DEPTH] = win[r][c];
    end
  end

`ifdef CELL_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles a cell waits on the processor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (cell_valid && !cell_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cell_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_window_sequencer
// Description : Randomized self-checking bench for cell_window_sequencer.
//               Expected windows are built directly from the image array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_window_sequencer;

  localparam int W      = 5;
  localparam int H      = 4;
  localparam int N      = 3;
  localparam int PD     = 24;
  localparam int OW     = 4;
  localparam int CW     = PD * N * N;
  localparam int XW     = $clog2(W);
  localparam int YW     = $clog2(H);
  localparam int HF     = (N - 1) / 2;
  localparam int NCELLS = (W - N + 1) * (H - N + 1);
  localparam logic [OW-1:0] OP_ADDI = 4'h1;
  localparam logic [OW-1:0] OP_SUB  = 4'h2;
`ifdef CELL_STALL_CNT_EN
  localparam int STALL_EXP = 4;
`else
  localparam int STALL_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [OW-1:0] opcode_in = '0;
  logic [PD-1:0] user_in = '0;
  logic [PD-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [CW-1:0] cell_out;
  logic          cell_valid;
  logic          cell_ready = 1'b0;
  logic [OW-1:0] opcode_out;
  logic [PD-1:0] user_out;
  logic [XW-1:0] cell_x;
  logic [YW-1:0] cell_y;
  logic          busy;
  logic          frame_done;
  logic [31:0]   stall_cycles;

  cell_window_sequencer #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .CELL_N      (N),
    .PIXEL_DEPTH (PD),
    .OPCODE_WIDTH(OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode_in   (opcode_in),
    .user_in     (user_in),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .cell_out    (cell_out),
    .cell_valid  (cell_valid),
    .cell_ready  (cell_ready),
    .opcode_out  (opcode_out),
    .user_out    (user_out),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .busy        (busy),
    .frame_done  (frame_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [PD-1:0] img [H][W];

  // Reference windows in raster order
  logic [CW-1:0] ex_cell[$];
  int            ex_x[$];
  int            ex_y[$];

  // Observations from the last frame
  logic [CW-1:0] ob_cell[$];
  int            ob_x[$];
  int            ob_y[$];
  logic [OW-1:0] ob_op[$];
  logic [PD-1:0] ob_usr[$];
  int            ob_valid_cyc[$];
  int            ex_valid_cyc[$];
  int            last_hand_cyc;
  int            done_cyc;
  int            hold_viol;
  int            ready_viol;
  int            extra_acc;
  int            timed_out;

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = PD'(r * 16 + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = PD'($urandom());
  endtask

  // Every window whose centre lies at least HF pixels from each border
  task automatic build_expected();
    logic [CW-1:0] v;
    ex_cell.delete(); ex_x.delete(); ex_y.delete();
    for (int cy = HF; cy <= H - 1 - HF; cy++) begin
      for (int cx = HF; cx <= W - 1 - HF; cx++) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            v[(r*N+c)*PD +: PD] = img[cy-HF+r][cx-HF+c];
        ex_cell.push_back(v);
        ex_x.push_back(cx);
        ex_y.push_back(cy);
      end
    end
  endtask

  // mode 0: always valid/ready, 1: pix_valid toggles, 2: random valid/ready.
  // stall_idx: hold cell_ready low 4 cycles while that cell (0-based) is
  // presented. mid_start: loop cycle at which to pulse start with SUB.
  // abort_after: return at a posedge+1 once that many cells were taken.
  task automatic run_frame(input logic [OW-1:0] opc, input logic [PD-1:0] usr,
                           input int mode, input int stall_idx,
                           input int mid_start, input int abort_after);
    int idx = 0;
    int hold = 0;
    int k = 0;
    bit done = 0;
    logic prev_valid = 1'b0;
    logic prev_hand = 1'b0;
    logic prev_stall = 1'b0;
    logic [CW-1:0] prev_cell = '0;
    logic [XW-1:0] prev_x = '0;
    logic [YW-1:0] prev_y = '0;
    ob_cell.delete(); ob_x.delete(); ob_y.delete(); ob_op.delete(); ob_usr.delete();
    ob_valid_cyc.delete(); ex_valid_cyc.delete();
    last_hand_cyc = -100; done_cyc = -1;
    hold_viol = 0; ready_viol = 0; extra_acc = 0; timed_out = 0;
    while (!done) begin
      @(posedge clk); #1;
      if (abort_after >= 0 && ob_cell.size() == abort_after) break;
      start     = (k == 0) || (mid_start > 0 && k == mid_start);
      opcode_in = (k == 0) ? opc : OP_SUB;
      user_in   = (k == 0) ? usr : 24'hABCDEF;
      if (mode == 1)      pix_valid = k[0];
      else if (mode == 2) pix_valid = ($urandom_range(0, 3) != 0);
      else                pix_valid = 1'b1;
      pix_in = (idx < W * H) ? img[idx/W][idx%W] : (24'hFFFFFF ^ PD'(k));
      if (cell_valid && ob_cell.size() == stall_idx && hold < 4) begin
        cell_ready = 1'b0;
        hold++;
      end else if (mode == 2) begin
        cell_ready = ($urandom_range(0, 2) != 0);
      end else begin
        cell_ready = 1'b1;
      end
      @(negedge clk);
      if (cell_valid && (!prev_valid || prev_hand)) ob_valid_cyc.push_back(cyc);
      if (prev_stall && (!cell_valid || cell_out !== prev_cell ||
                         cell_x !== prev_x || cell_y !== prev_y)) hold_viol++;
      if (cell_valid && !cell_ready && pix_ready) ready_viol++;
      if (pix_valid && pix_ready) begin
        if (idx >= W * H) begin
          extra_acc++;
        end else begin
          if ((idx % W) >= N - 1 && (idx / W) >= N - 1) ex_valid_cyc.push_back(cyc + 1);
          idx++;
        end
      end
      if (cell_valid && cell_ready) begin
        ob_cell.push_back(cell_out);
        ob_x.push_back(int'(cell_x));
        ob_y.push_back(int'(cell_y));
        ob_op.push_back(opcode_out);
        ob_usr.push_back(user_out);
        last_hand_cyc = cyc;
      end
      if (frame_done) begin
        done_cyc = cyc;
        done = 1;
      end
      prev_valid = cell_valid;
      prev_hand  = cell_valid && cell_ready;
      prev_stall = cell_valid && !cell_ready;
      prev_cell  = cell_out;
      prev_x     = cell_x;
      prev_y     = cell_y;
      k++;
      if (k > 400) begin
        timed_out = 1;
        done = 1;
      end
    end
    start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({pix_ready, cell_valid, busy, frame_done, cell_out, opcode_out, user_out,
         cell_x, cell_y, stall_cycles} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b valid=%b busy=%b done=%b cell=%h op=%h, required all 0",
               pix_ready, cell_valid, busy, frame_done, cell_out, opcode_out);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({pix_ready, cell_valid, busy, frame_done} !== 4'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got ready=%b valid=%b busy=%b done=%b, required 0000",
               pix_ready, cell_valid, busy, frame_done);
    end
  endtask

  task automatic test_idle_pix();
    pix_valid = 1'b1;
    cell_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pix_in = PD'($urandom());
      @(negedge clk);
      tests++;
      if ({pix_ready, cell_valid, busy} !== 3'b000) begin
        fails++;
        $display("FAIL idle_pix_ignored: got ready=%b valid=%b busy=%b, required 000",
                 pix_ready, cell_valid, busy);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [CW-1:0] c0;
    int lat_bad;
    fill_ramp();
    build_expected();
    run_frame(OP_ADDI, 24'h010101, 0, -1, 0, -1);
    tests++;
    if (timed_out !== 0 || ob_cell.size() !== NCELLS) begin
      fails++;
      $display("FAIL basic_count: got %0d cells (timeout=%0d), required %0d", ob_cell.size(), timed_out, NCELLS);
    end
    c0 = (ob_cell.size() > 0) ? ob_cell[0] : '0;
    tests++;
    if (ob_x.size() == 0 || ob_x[0] !== 1 || ob_y[0] !== 1 || c0[4*PD +: PD] !== 24'h11 ||
        c0[0 +: PD] !== 24'h00 || c0[8*PD +: PD] !== 24'h22) begin
      fails++;
      $display("FAIL basic_first_cell: got cell=%h, required x=1 y=1 centre=11 pm0=00 pm8=22", c0);
    end
    for (int i = 0; i < ex_cell.size() && i < ob_cell.size(); i++) begin
      tests++;
      if (ob_cell[i] !== ex_cell[i] || ob_x[i] !== ex_x[i] || ob_y[i] !== ex_y[i] ||
          ob_op[i] !== OP_ADDI || ob_usr[i] !== 24'h010101) begin
        fails++;
        $display("FAIL basic_cell%0d: got %h x=%0d y=%0d op=%h usr=%h, required %h x=%0d y=%0d op=%h usr=010101",
                 i, ob_cell[i], ob_x[i], ob_y[i], ob_op[i], ob_usr[i], ex_cell[i], ex_x[i], ex_y[i], OP_ADDI);
      end
    end
    lat_bad = (ob_valid_cyc.size() != ex_valid_cyc.size()) ? 1 : 0;
    for (int i = 0; i < ob_valid_cyc.size() && i < ex_valid_cyc.size(); i++)
      if (ob_valid_cyc[i] != ex_valid_cyc[i]) lat_bad++;
    tests++;
    if (lat_bad !== 0) begin
      fails++;
      $display("FAIL basic_latency: got %0d cells off the accept+1 cycle, required 0", lat_bad);
    end
    tests++;
    if (done_cyc !== last_hand_cyc + 1 || extra_acc !== 0) begin
      fails++;
      $display("FAIL basic_done: got done at %0d extra_acc=%0d, required %0d and 0", done_cyc, extra_acc, last_hand_cyc + 1);
    end
    @(negedge clk);
    tests++;
    if ({busy, frame_done, pix_ready} !== 3'b000 || stall_cycles !== 32'd0) begin
      fails++;
      $display("FAIL basic_after: got busy=%b done=%b ready=%b stall=%0d, required 0 0 0 0",
               busy, frame_done, pix_ready, stall_cycles);
    end
  endtask

  task automatic test_stall();
    fill_ramp();
    build_expected();
    run_frame(OP_ADDI, 24'h010101, 0, 2, 0, -1);
    tests++;
    if (timed_out !== 0 || ob_cell.size() !== NCELLS) begin
      fails++;
      $display("FAIL stall_count: got %0d cells (timeout=%0d), required %0d", ob_cell.size(), timed_out, NCELLS);
    end
    for (int i = 0; i < ex_cell.size() && i < ob_cell.size(); i++) begin
      tests++;
      if (ob_cell[i] !== ex_cell[i] || ob_x[i] !== ex_x[i] || ob_y[i] !== ex_y[i]) begin
        fails++;
        $display("FAIL stall_cell%0d: got %h x=%0d y=%0d, required %h x=%0d y=%0d",
                 i, ob_cell[i], ob_x[i], ob_y[i], ex_cell[i], ex_x[i], ex_y[i]);
      end
    end
    tests++;
    if (hold_viol !== 0 || ready_viol !== 0) begin
      fails++;
      $display("FAIL stall_hold: got %0d unstable cycles, %0d ready-during-hold cycles, required 0 and 0",
               hold_viol, ready_viol);
    end
    tests++;
    if (stall_cycles !== 32'(STALL_EXP)) begin
      fails++;
      $display("FAIL stall_counter: got %0d, required %0d", stall_cycles, STALL_EXP);
    end
  endtask

  task automatic test_start_ignored();
    int bad = 0;
    fill_ramp();
    build_expected();
    run_frame(OP_ADDI, 24'h5A5A5A, 0, -1, 8, -1);
    tests++;
    if (timed_out !== 0 || ob_cell.size() !== NCELLS) begin
      fails++;
      $display("FAIL midstart_count: got %0d cells (timeout=%0d), required %0d", ob_cell.size(), timed_out, NCELLS);
    end
    for (int i = 0; i < ob_cell.size() && i < ex_cell.size(); i++)
      if (ob_op[i] !== OP_ADDI || ob_usr[i] !== 24'h5A5A5A || ob_cell[i] !== ex_cell[i]) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL midstart_cells: got %0d cells with wrong op/user/data, required 0", bad);
    end
    @(negedge clk);
    tests++;
    if (opcode_out !== OP_ADDI || busy !== 1'b0) begin
      fails++;
      $display("FAIL midstart_after: got op=%h busy=%b, required %h 0", opcode_out, busy, OP_ADDI);
    end
  endtask

  task automatic test_midframe_reset();
    int seen_done = 0;
    fill_random();
    run_frame(OP_ADDI, 24'h123456, 0, -1, 0, 3);
    rst = 1'b0;
    #1;
    tests++;
    if ({pix_ready, cell_valid, busy, frame_done, cell_out, opcode_out, user_out,
         cell_x, cell_y, stall_cycles} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got ready=%b valid=%b busy=%b cell=%h op=%h usr=%h, required all 0",
               pix_ready, cell_valid, busy, cell_out, opcode_out, user_out);
    end
    repeat (3) begin
      @(negedge clk);
      if (frame_done) seen_done++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (frame_done) seen_done++;
    end
    tests++;
    if (seen_done !== 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d frame_done pulses, required 0", seen_done);
    end
    fill_random();
    build_expected();
    run_frame(OP_SUB, 24'h00FF00, 0, -1, 0, -1);
    tests++;
    if (timed_out !== 0 || ob_cell.size() !== NCELLS || ob_x[0] !== 1 || ob_y[0] !== 1) begin
      fails++;
      $display("FAIL restart_count: got %0d cells (timeout=%0d), required %0d from x=1 y=1",
               ob_cell.size(), timed_out, NCELLS);
    end
    for (int i = 0; i < ex_cell.size() && i < ob_cell.size(); i++) begin
      tests++;
      if (ob_cell[i] !== ex_cell[i] || ob_x[i] !== ex_x[i] || ob_y[i] !== ex_y[i] || ob_op[i] !== OP_SUB) begin
        fails++;
        $display("FAIL restart_cell%0d: got %h x=%0d y=%0d op=%h, required %h x=%0d y=%0d op=%h",
                 i, ob_cell[i], ob_x[i], ob_y[i], ob_op[i], ex_cell[i], ex_x[i], ex_y[i], OP_SUB);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat_bad;
    fill_ramp();
    build_expected();
    run_frame(OP_ADDI, 24'h010101, 1, -1, 0, -1);
    tests++;
    if (timed_out !== 0 || ob_cell.size() !== NCELLS) begin
      fails++;
      $display("FAIL toggle_count: got %0d cells (timeout=%0d), required %0d", ob_cell.size(), timed_out, NCELLS);
    end
    for (int i = 0; i < ex_cell.size() && i < ob_cell.size(); i++) begin
      tests++;
      if (ob_cell[i] !== ex_cell[i] || ob_x[i] !== ex_x[i] || ob_y[i] !== ex_y[i]) begin
        fails++;
        $display("FAIL toggle_cell%0d: got %h x=%0d y=%0d, required %h x=%0d y=%0d",
                 i, ob_cell[i], ob_x[i], ob_y[i], ex_cell[i], ex_x[i], ex_y[i]);
      end
    end
    lat_bad = (ob_valid_cyc.size() != ex_valid_cyc.size()) ? 1 : 0;
    for (int i = 0; i < ob_valid_cyc.size() && i < ex_valid_cyc.size(); i++)
      if (ob_valid_cyc[i] != ex_valid_cyc[i]) lat_bad++;
    tests++;
    if (lat_bad !== 0 || done_cyc !== last_hand_cyc + 1) begin
      fails++;
      $display("FAIL toggle_timing: got %0d latency errors, done at %0d, required 0 and %0d",
               lat_bad, done_cyc, last_hand_cyc + 1);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] opc;
    logic [PD-1:0] usr;
    int bad;
    int lat_bad;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      build_expected();
      opc = OW'($urandom());
      usr = PD'($urandom());
      run_frame(opc, usr, 2, -1, 0, -1);
      bad = (timed_out != 0 || ob_cell.size() != NCELLS) ? 1 : 0;
      for (int i = 0; i < ex_cell.size() && i < ob_cell.size(); i++)
        if (ob_cell[i] !== ex_cell[i] || ob_x[i] !== ex_x[i] || ob_y[i] !== ex_y[i] ||
            ob_op[i] !== opc || ob_usr[i] !== usr) bad++;
      tests++;
      if (bad !== 0) begin
        fails++;
        $display("FAIL random%0d_cells: got %0d bad cells of %0d (timeout=%0d), required 0 of %0d",
                 f, bad, ob_cell.size(), timed_out, NCELLS);
      end
      lat_bad = (ob_valid_cyc.size() != ex_valid_cyc.size()) ? 1 : 0;
      for (int i = 0; i < ob_valid_cyc.size() && i < ex_valid_cyc.size(); i++)
        if (ob_valid_cyc[i] != ex_valid_cyc[i]) lat_bad++;
      tests++;
      if (lat_bad !== 0 || hold_viol !== 0 || ready_viol !== 0 || extra_acc !== 0 ||
          done_cyc !== last_hand_cyc + 1) begin
        fails++;
        $display("FAIL random%0d_protocol: got lat=%0d hold=%0d ready=%0d extra=%0d done=%0d, required 0 0 0 0 %0d",
                 f, lat_bad, hold_viol, ready_viol, extra_acc, done_cyc, last_hand_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_pix();
    test_basic();
    test_stall();
    test_start_ignored();
    test_midframe_reset();
    test_back_to_back();
    test_random();
    test_idle_pix();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
